// File: rtl/lalu_mem_pkg.sv
// Shared types and constants for the LALU memory arbiter.
package lalu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_e;

  localparam int MEM_LAT_MAX = 4;
  localparam int CNT_W       = 3;

endpackage

// File: rtl/lalu_arb_pick.sv
// Combinational 2-way picker: round-robin on contention, or fixed LS priority
// when LS_PRIORITY is set.
module lalu_arb_pick
  import lalu_mem_pkg::*;
#(
  parameter bit LS_PRIORITY = 1'b0
) (
  input  logic if_req,
  input  logic ls_req,
  input  logic last_winner,
  output logic winner,
  output logic valid
);

  always_comb begin
    valid  = if_req | ls_req;
    winner = REQ_IF;
    if (if_req && ls_req) begin
      // Contention goes to whoever did not win last, unless LS is favoured.
      if (LS_PRIORITY)
        winner = REQ_LS;
      else
        winner = (last_winner == REQ_IF) ? REQ_LS : REQ_IF;
    end else if (ls_req) begin
      winner = REQ_LS;
    end
  end

endmodule

// File: rtl/lalu_mem_arbiter.sv
// Shares the single-port LALU memory between instruction fetch and load/store.
// Define LALU_ARB_LS_PRIORITY_EN to give LS fixed priority instead of round-robin.
module lalu_mem_arbiter
  import lalu_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
      $error("lalu_mem_arbiter: MEM_LAT must be in 1..4");
    end
  endgenerate

`ifdef LALU_ARB_LS_PRIORITY_EN
  localparam bit LS_PRIORITY = 1'b1;
`else
  localparam bit LS_PRIORITY = 1'b0;
`endif

  arb_state_e              state_reg;
  req_id_e                 winner_reg;
  req_id_e                 last_winner_reg;
  logic [ADDR_W-1:0]       addr_reg;
  logic                    we_reg;
  logic [DATA_W-1:0]       wdata_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    mem_en_reg;
  logic                    mem_we_reg;
  logic [1:0]              gnt_reg;
  logic [1:0]              rvalid_reg;
  logic [1:0][DATA_W-1:0]  rdata_reg;

  logic pick_winner;
  logic pick_valid;

  lalu_arb_pick #(
    .LS_PRIORITY (LS_PRIORITY)
  ) u_pick (
    .if_req      (if_req),
    .ls_req      (ls_req),
    .last_winner (last_winner_reg),
    .winner      (pick_winner),
    .valid       (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      winner_reg      <= REQ_IF;
      last_winner_reg <= REQ_IF;
      addr_reg        <= '0;
      we_reg          <= 1'b0;
      wdata_reg       <= '0;
      cnt_reg         <= '0;
      mem_en_reg      <= 1'b0;
      mem_we_reg      <= 1'b0;
      gnt_reg         <= '0;
      rvalid_reg      <= '0;
      rdata_reg       <= '0;
    end else begin
      // Strobes and pulses are single-cycle unless re-asserted below.
      mem_en_reg <= 1'b0;
      mem_we_reg <= 1'b0;
      gnt_reg    <= '0;
      rvalid_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            winner_reg <= req_id_e'(pick_winner);
            if (pick_winner == REQ_LS) begin
              addr_reg   <= ls_addr;
              we_reg     <= ls_we;
              wdata_reg  <= ls_wdata;
              mem_we_reg <= ls_we;
              gnt_reg    <= 2'b10;
            end else begin
              addr_reg   <= if_addr;
              we_reg     <= 1'b0;
              wdata_reg  <= '0;
              gnt_reg    <= 2'b01;
            end
            mem_en_reg <= 1'b1;
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          last_winner_reg <= winner_reg;
          if (we_reg) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg   <= CNT_W'(MEM_LAT);
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            rdata_reg[winner_reg]  <= mem_rdata;
            rvalid_reg[winner_reg] <= 1'b1;
            state_reg              <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign if_gnt    = gnt_reg[REQ_IF];
  assign ls_gnt    = gnt_reg[REQ_LS];
  assign if_rvalid = rvalid_reg[REQ_IF];
  assign ls_rvalid = rvalid_reg[REQ_LS];
  assign if_rdata  = rdata_reg[REQ_IF];
  assign ls_rdata  = rdata_reg[REQ_LS];
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_lalu_mem_arbiter.sv
// Directed bench for lalu_mem_arbiter: one MEM_LAT=1 instance and one MEM_LAT=4 instance.
module tb_lalu_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, ls_req, ls_we;
  logic [15:0] if_addr, ls_addr;
  logic [31:0] ls_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, ls_rdata, mem_wdata;
  logic [15:0] mem_addr;

  logic        if4_req, ls4_req, ls4_we;
  logic [15:0] if4_addr, ls4_addr;
  logic [31:0] ls4_wdata, mem4_rdata;
  logic        if4_gnt, if4_rvalid, ls4_gnt, ls4_rvalid, mem4_en, mem4_we, busy4;
  logic [31:0] if4_rdata, ls4_rdata, mem4_wdata;
  logic [15:0] mem4_addr;

  int checks = 0;
  int passed = 0;

  lalu_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  lalu_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(4)) dut4 (
    .clk(clk), .rst(rst),
    .if_req(if4_req), .if_addr(if4_addr), .if_gnt(if4_gnt), .if_rvalid(if4_rvalid), .if_rdata(if4_rdata),
    .ls_req(ls4_req), .ls_we(ls4_we), .ls_addr(ls4_addr), .ls_wdata(ls4_wdata),
    .ls_gnt(ls4_gnt), .ls_rvalid(ls4_rvalid), .ls_rdata(ls4_rdata),
    .mem_en(mem4_en), .mem_we(mem4_we), .mem_addr(mem4_addr), .mem_wdata(mem4_wdata),
    .mem_rdata(mem4_rdata), .busy(busy4)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) step;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step;
      checks++;
      if ({if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, mem_en, mem_we,
           mem_addr, mem_wdata, busy} !== '0)
        $display("FAIL reset_outputs cycle %0d: got gnt=%b/%b rv=%b/%b en=%b we=%b addr=%h busy=%b, want all 0",
                 c, if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, mem_addr, busy);
      else passed++;
    end
    $display("reset: 5 idle cycles observed");
  endtask

  task automatic test_if_read;
    if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 32'hDEADBEEF;
    step;
    checks++;
    if ({mem_en, mem_we, if_gnt, ls_gnt, mem_addr} !== {4'b1010, 16'h0010})
      $display("FAIL if_read_issue: got en=%b we=%b if_gnt=%b ls_gnt=%b addr=%h, want 1 0 1 0 0010",
               mem_en, mem_we, if_gnt, ls_gnt, mem_addr);
    else passed++;
    if_req = 1'b0;
    step;
    checks++;
    if ({mem_en, busy, if_rvalid} !== 3'b010)
      $display("FAIL if_read_wait: got en=%b busy=%b rvalid=%b, want 0 1 0", mem_en, busy, if_rvalid);
    else passed++;
    step;
    checks++;
    if ({if_rvalid, ls_rvalid, busy, if_rdata} !== {3'b100, 32'hDEADBEEF})
      $display("FAIL if_read_rvalid: got rvalid=%b ls_rvalid=%b busy=%b data=%h, want 1 0 0 deadbeef",
               if_rvalid, ls_rvalid, busy, if_rdata);
    else passed++;
    mem_rdata = 32'h0;
    step;
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b0, 32'hDEADBEEF})
      $display("FAIL if_read_hold: got rvalid=%b data=%h, want 0 deadbeef", if_rvalid, if_rdata);
    else passed++;
    $display("if read addr=0010 data=%h", if_rdata);
  endtask

  task automatic test_ls_store;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0020; ls_wdata = 32'h12345678;
    step;
    checks++;
    if ({mem_en, mem_we, ls_gnt, if_gnt, mem_addr, mem_wdata} !== {4'b1110, 16'h0020, 32'h12345678})
      $display("FAIL ls_store_issue: got en=%b we=%b ls_gnt=%b if_gnt=%b addr=%h wdata=%h, want 1 1 1 0 0020 12345678",
               mem_en, mem_we, ls_gnt, if_gnt, mem_addr, mem_wdata);
    else passed++;
    ls_req = 1'b0; ls_we = 1'b0;
    step;
    checks++;
    if ({busy, ls_rvalid, mem_en, mem_we} !== 4'b0000)
      $display("FAIL ls_store_done: got busy=%b rvalid=%b en=%b we=%b, want 0 0 0 0", busy, ls_rvalid, mem_en, mem_we);
    else passed++;
    step;
    checks++;
    if (ls_rvalid !== 1'b0)
      $display("FAIL ls_store_no_rvalid: got %b, want 0", ls_rvalid);
    else passed++;
    $display("ls store addr=0020 data=12345678");
  endtask

  task automatic test_round_robin;
    bit order[4];
    bit exp_ls;
    int n;
    rst = 1'b1;
    step;
    rst = 1'b0;
    if_req = 1'b1; if_addr = 16'h0040;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0030; ls_wdata = 32'hCAFE0001;
    mem_rdata = 32'h11112222;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step;
      checks++;
      if ((if_gnt && ls_gnt) || (if_rvalid && ls_rvalid))
        $display("FAIL rr_exclusive cycle %0d: got gnt=%b%b rvalid=%b%b, want at most one",
                 c, if_gnt, ls_gnt, if_rvalid, ls_rvalid);
      else passed++;
      if (if_gnt || ls_gnt) begin
        order[n] = ls_gnt;
        checks++;
        if (mem_addr !== (ls_gnt ? 16'h0030 : 16'h0040))
          $display("FAIL rr_addr grant %0d: got %h, want %h", n, mem_addr, ls_gnt ? 16'h0030 : 16'h0040);
        else passed++;
        $display("rr grant %0d to %s addr=%h", n, ls_gnt ? "LS" : "IF", mem_addr);
        n++;
      end
    end
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    checks++;
    if (n !== 4)
      $display("FAIL rr_grant_count: got %0d grants in 40 cycles, want 4", n);
    else passed++;
    for (int i = 0; i < n; i++) begin
`ifdef LALU_ARB_LS_PRIORITY_EN
      exp_ls = 1'b1;
`else
      exp_ls = (i % 2 == 0);
`endif
      checks++;
      if (order[i] !== exp_ls)
        $display("FAIL rr_order grant %0d: got %s, want %s", i, order[i] ? "LS" : "IF", exp_ls ? "LS" : "IF");
      else passed++;
    end
    repeat (4) step;
  endtask

  task automatic test_lat4_load;
    ls4_req = 1'b1; ls4_we = 1'b0; ls4_addr = 16'h00FF; mem4_rdata = 32'h0;
    for (int k = 1; k <= 7; k++) begin
      step;
      mem4_rdata = 32'hA0000000 + 32'(k - 1);
      if (k == 1) begin
        checks++;
        if ({ls4_gnt, mem4_en, mem4_we, mem4_addr} !== {3'b110, 16'h00FF})
          $display("FAIL lat4_issue: got gnt=%b en=%b we=%b addr=%h, want 1 1 0 00ff",
                   ls4_gnt, mem4_en, mem4_we, mem4_addr);
        else passed++;
        ls4_req = 1'b0;
      end
      checks++;
      if (ls4_rvalid !== (k == 6))
        $display("FAIL lat4_rvalid cycle %0d: got %b, want %b", k, ls4_rvalid, k == 6);
      else passed++;
      if (k == 6) begin
        checks++;
        if (ls4_rdata !== 32'hA0000004)
          $display("FAIL lat4_rdata: got %h, want a0000004", ls4_rdata);
        else passed++;
        $display("lat4 load addr=00ff data=%h", ls4_rdata);
      end
    end
  endtask

  task automatic test_reset_in_wait;
    step;
    if_req = 1'b1; if_addr = 16'h0050; mem_rdata = 32'h55AA55AA;
    step;
    checks++;
    if (if_gnt !== 1'b1)
      $display("FAIL rstwait_gnt: got %b, want 1", if_gnt);
    else passed++;
    if_req = 1'b0;
    step;
    checks++;
    if (busy !== 1'b1)
      $display("FAIL rstwait_in_wait: got busy=%b, want 1", busy);
    else passed++;
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++;
    if ({busy, if_rvalid, if_rdata, mem_en} !== '0)
      $display("FAIL rstwait_abandon: got busy=%b rvalid=%b data=%h en=%b, want 0 0 0 0",
               busy, if_rvalid, if_rdata, mem_en);
    else passed++;
    for (int c = 0; c < 3; c++) begin
      step;
      checks++;
      if ({if_rvalid, mem_en} !== 2'b00)
        $display("FAIL rstwait_quiet cycle %0d: got rvalid=%b en=%b, want 0 0", c, if_rvalid, mem_en);
      else passed++;
    end
    if_req = 1'b1; if_addr = 16'h0060; mem_rdata = 32'h0BADF00D;
    step;
    checks++;
    if ({if_gnt, mem_en, mem_addr} !== {2'b11, 16'h0060})
      $display("FAIL rstwait_reissue: got gnt=%b en=%b addr=%h, want 1 1 0060", if_gnt, mem_en, mem_addr);
    else passed++;
    if_req = 1'b0;
    step;
    step;
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h0BADF00D})
      $display("FAIL rstwait_read: got rvalid=%b data=%h, want 1 0badf00d", if_rvalid, if_rdata);
    else passed++;
    $display("post-reset if read addr=0060 data=%h", if_rdata);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
    if4_req = 1'b0; if4_addr = '0; ls4_req = 1'b0; ls4_we = 1'b0; ls4_addr = '0; ls4_wdata = '0; mem4_rdata = '0;
    test_reset;
    test_if_read;
    test_ls_store;
    test_round_robin;
    test_lat4_load;
    test_reset_in_wait;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
